// File: rtl/alu_cmd_issuer.sv
// Initiator for a 4-bit combinational ALU: registers operands, captures r/c/v one cycle
// later into an in-order response FIFO, and maintains an accumulator plus sticky flags.
module alu_cmd_issuer #(
    parameter int RSP_DEPTH = 2
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       cmd_valid,
    output logic       cmd_ready,
    input  logic [3:0] cmd_a,
    input  logic [3:0] cmd_b,
    input  logic [2:0] cmd_s,
    input  logic       cmd_acc,
    input  logic       cmd_wb,
    output logic [3:0] alu_a,
    output logic [3:0] alu_b,
    output logic [2:0] alu_s,
    input  logic [3:0] alu_r,
    input  logic       alu_c,
    input  logic       alu_v,
    output logic       rsp_valid,
    input  logic       rsp_ready,
    output logic [3:0] rsp_r,
    output logic       rsp_c,
    output logic       rsp_v,
    output logic       rsp_z,
    output logic [3:0] acc,
    output logic       sticky_c,
    output logic       sticky_v,
    input  logic       clr_sticky,
    output logic       dbg_state
);
    // Handshakes: a transfer happens on any rising edge where valid and ready are both high;
    // ready never depends combinationally on valid, and valid/payload hold until transferred.

    typedef enum logic {IDLE = 1'b0, EXEC = 1'b1} state_t;

    localparam int PW = (RSP_DEPTH > 1) ? $clog2(RSP_DEPTH) : 1;
    localparam int CW = $clog2(RSP_DEPTH + 1);

    state_t        state_q, state_d;
    logic [3:0]    alu_a_q, alu_a_d;
    logic [3:0]    alu_b_q, alu_b_d;
    logic [2:0]    alu_s_q, alu_s_d;
    logic          wb_q, wb_d;
    logic [3:0]    acc_q, acc_d;
    logic          sticky_c_q, sticky_c_d;
    logic          sticky_v_q, sticky_v_d;
    logic [6:0]    fifo_q [RSP_DEPTH];
    logic [PW-1:0] wr_ptr_q, wr_ptr_d;
    logic [PW-1:0] rd_ptr_q, rd_ptr_d;
    logic [CW-1:0] count_q, count_d;
    logic          accept, push, pop;
    logic [6:0]    push_entry, head;

    function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
        return (p == PW'(RSP_DEPTH - 1)) ? '0 : p + PW'(1);
    endfunction

    always_comb begin
        // The FIFO slot is reserved at accept, so the capture push can never find it full.
        cmd_ready  = (state_q == IDLE) && (count_q < CW'(RSP_DEPTH));
        accept     = cmd_valid && cmd_ready;
        push       = (state_q == EXEC);
        rsp_valid  = (count_q != '0);
        pop        = rsp_valid && rsp_ready;
        push_entry = {alu_r, alu_c, alu_v, (alu_r == 4'h0)};
        head       = fifo_q[rd_ptr_q];

        state_d    = state_q;
        alu_a_d    = alu_a_q;
        alu_b_d    = alu_b_q;
        alu_s_d    = alu_s_q;
        wb_d       = wb_q;
        acc_d      = acc_q;
        sticky_c_d = sticky_c_q;
        sticky_v_d = sticky_v_q;
        wr_ptr_d   = wr_ptr_q;
        rd_ptr_d   = rd_ptr_q;
        count_d    = count_q;

        case (state_q)
            IDLE: if (accept) state_d = EXEC;
            EXEC: state_d = IDLE;
            default: state_d = IDLE;
        endcase

        if (accept) begin
            alu_a_d = cmd_acc ? acc_q : cmd_a;
            alu_b_d = cmd_b;
            alu_s_d = cmd_s;
            wb_d    = cmd_wb;
        end

        if (push) begin
            wr_ptr_d = ptr_inc(wr_ptr_q);
            if (wb_q) acc_d = alu_r;
        end
        if (pop) rd_ptr_d = ptr_inc(rd_ptr_q);

        case ({push, pop})
            2'b10:   count_d = count_q + CW'(1);
            2'b01:   count_d = count_q - CW'(1);
            default: count_d = count_q;
        endcase

        // A flag captured this edge beats a simultaneous clear.
        if (push && alu_c)   sticky_c_d = 1'b1;
        else if (clr_sticky) sticky_c_d = 1'b0;
        if (push && alu_v)   sticky_v_d = 1'b1;
        else if (clr_sticky) sticky_v_d = 1'b0;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= IDLE;
            alu_a_q    <= '0;
            alu_b_q    <= '0;
            alu_s_q    <= '0;
            wb_q       <= 1'b0;
            acc_q      <= '0;
            sticky_c_q <= 1'b0;
            sticky_v_q <= 1'b0;
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            count_q    <= '0;
            for (int i = 0; i < RSP_DEPTH; i++) fifo_q[i] <= '0;
        end else begin
            state_q    <= state_d;
            alu_a_q    <= alu_a_d;
            alu_b_q    <= alu_b_d;
            alu_s_q    <= alu_s_d;
            wb_q       <= wb_d;
            acc_q      <= acc_d;
            sticky_c_q <= sticky_c_d;
            sticky_v_q <= sticky_v_d;
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            count_q    <= count_d;
            if (push) fifo_q[wr_ptr_q] <= push_entry;
        end
    end

    assign alu_a     = alu_a_q;
    assign alu_b     = alu_b_q;
    assign alu_s     = alu_s_q;
    assign acc       = acc_q;
    assign sticky_c  = sticky_c_q;
    assign sticky_v  = sticky_v_q;
    assign dbg_state = state_q;
    // Response fields read as zero whenever the FIFO is empty.
    assign rsp_r     = rsp_valid ? head[6:3] : 4'h0;
    assign rsp_c     = rsp_valid ? head[2]   : 1'b0;
    assign rsp_v     = rsp_valid ? head[1]   : 1'b0;
    assign rsp_z     = rsp_valid ? head[0]   : 1'b0;

endmodule

// File: tb/tb_alu_cmd_issuer.sv
// Directed bench for alu_cmd_issuer with a stub adder ALU; inputs driven and outputs
// sampled on the falling edge.
module tb_alu_cmd_issuer;
    logic       clk;
    logic       rst;
    logic       cmd_valid, cmd_ready;
    logic [3:0] cmd_a, cmd_b;
    logic [2:0] cmd_s;
    logic       cmd_acc, cmd_wb;
    logic [3:0] alu_a, alu_b;
    logic [2:0] alu_s;
    logic [3:0] alu_r;
    logic       alu_c, alu_v;
    logic       rsp_valid, rsp_ready;
    logic [3:0] rsp_r;
    logic       rsp_c, rsp_v, rsp_z;
    logic [3:0] acc;
    logic       sticky_c, sticky_v, clr_sticky;
    logic       dbg_state;

    logic [4:0] alu_sum;
    logic [6:0] exp_q[$];
    logic [3:0] acc_m;
    int         n_checks;
    int         n_fail;

    alu_cmd_issuer #(.RSP_DEPTH(2)) dut (
        .clk(clk), .rst(rst),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
        .cmd_a(cmd_a), .cmd_b(cmd_b), .cmd_s(cmd_s), .cmd_acc(cmd_acc), .cmd_wb(cmd_wb),
        .alu_a(alu_a), .alu_b(alu_b), .alu_s(alu_s),
        .alu_r(alu_r), .alu_c(alu_c), .alu_v(alu_v),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
        .rsp_r(rsp_r), .rsp_c(rsp_c), .rsp_v(rsp_v), .rsp_z(rsp_z),
        .acc(acc), .sticky_c(sticky_c), .sticky_v(sticky_v), .clr_sticky(clr_sticky),
        .dbg_state(dbg_state)
    );

    // Stub ALU: 4-bit add, select ignored.
    always_comb begin
        alu_sum = {1'b0, alu_a} + {1'b0, alu_b};
        alu_r   = alu_sum[3:0];
        alu_c   = alu_sum[4];
        alu_v   = (alu_a[3] == alu_b[3]) && (alu_sum[3] != alu_a[3]);
    end

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // Present one command at a falling edge, returning on the falling edge after acceptance.
    task automatic send_cmd(input logic [3:0] a, input logic [3:0] b, input logic [2:0] s,
                            input logic use_acc, input logic wb);
        logic [3:0] a_eff;
        logic [4:0] sum;
        logic       v;
        int         waited;
        waited = 0;
        while (!cmd_ready && waited < 20) begin
            @(negedge clk);
            waited++;
        end
        n_checks++;
        if (cmd_ready !== 1'b1) begin
            n_fail++;
            $display("FAIL send_cmd_ready_timeout: cmd_ready=%b required 1", cmd_ready);
        end else begin
            cmd_valid = 1'b1; cmd_a = a; cmd_b = b; cmd_s = s; cmd_acc = use_acc; cmd_wb = wb;
            a_eff = use_acc ? acc_m : a;
            sum   = {1'b0, a_eff} + {1'b0, b};
            v     = (a_eff[3] == b[3]) && (sum[3] != a_eff[3]);
            exp_q.push_back({sum[3:0], sum[4], v, (sum[3:0] == 4'h0)});
            if (wb) acc_m = sum[3:0];
            @(negedge clk);
            cmd_valid = 1'b0;
        end
    endtask

    task automatic test_reset;
        rst = 1'b1;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        exp_q.delete();
        acc_m = 4'h0;
        n_checks++;
        if ({cmd_ready, rsp_valid, dbg_state} !== 3'b100) begin
            n_fail++;
            $display("FAIL reset_handshake: ready/rsp_valid/state=%b required 100",
                     {cmd_ready, rsp_valid, dbg_state});
        end
        n_checks++;
        if ({alu_a, alu_b, alu_s, acc} !== 15'h0) begin
            n_fail++;
            $display("FAIL reset_regs: alu_a=%h alu_b=%h alu_s=%h acc=%h required all 0",
                     alu_a, alu_b, alu_s, acc);
        end
        n_checks++;
        if ({sticky_c, sticky_v, rsp_r, rsp_c, rsp_v, rsp_z} !== 9'h0) begin
            n_fail++;
            $display("FAIL reset_flags: sticky=%b%b rsp=%h%b%b%b required all 0",
                     sticky_c, sticky_v, rsp_r, rsp_c, rsp_v, rsp_z);
        end
    endtask

    task automatic test_basic;
        send_cmd(4'd7, 4'd1, 3'd5, 1'b0, 1'b1);
        n_checks++;
        if ({alu_a, alu_b, alu_s} !== {4'd7, 4'd1, 3'd5}) begin
            n_fail++;
            $display("FAIL basic_operands: a=%h b=%h s=%h required 7 1 5", alu_a, alu_b, alu_s);
        end
        n_checks++;
        if ({cmd_ready, rsp_valid, dbg_state} !== 3'b001) begin
            n_fail++;
            $display("FAIL basic_exec: ready/rsp_valid/state=%b required 001",
                     {cmd_ready, rsp_valid, dbg_state});
        end
        @(negedge clk);
        n_checks++;
        if ({rsp_valid, rsp_r, rsp_c, rsp_v, rsp_z} !== {1'b1, 4'd8, 3'b010}) begin
            n_fail++;
            $display("FAIL basic_rsp: v=%b r=%h c=%b v=%b z=%b required 1 8 0 1 0",
                     rsp_valid, rsp_r, rsp_c, rsp_v, rsp_z);
        end
        n_checks++;
        if ({acc, cmd_ready} !== {4'd8, 1'b1}) begin
            n_fail++;
            $display("FAIL basic_acc: acc=%h ready=%b required 8 1", acc, cmd_ready);
        end
        rsp_ready = 1'b1;
        @(negedge clk);
        rsp_ready = 1'b0;
        void'(exp_q.pop_front());
        n_checks++;
        if (rsp_valid !== 1'b0) begin
            n_fail++;
            $display("FAIL basic_pop: rsp_valid=%b required 0", rsp_valid);
        end
    endtask

    task automatic test_acc_source;
        send_cmd(4'd3, 4'd8, 3'd2, 1'b1, 1'b0);
        n_checks++;
        if ({alu_a, alu_b} !== {4'd8, 4'd8}) begin
            n_fail++;
            $display("FAIL acc_operand: alu_a=%h alu_b=%h required 8 8", alu_a, alu_b);
        end
        @(negedge clk);
        n_checks++;
        if ({rsp_valid, rsp_r, rsp_c, rsp_v, rsp_z} !== {1'b1, 4'd0, 3'b111}) begin
            n_fail++;
            $display("FAIL acc_rsp: v=%b r=%h c=%b v=%b z=%b required 1 0 1 1 1",
                     rsp_valid, rsp_r, rsp_c, rsp_v, rsp_z);
        end
        n_checks++;
        if ({sticky_c, sticky_v, acc} !== {2'b11, 4'd8}) begin
            n_fail++;
            $display("FAIL acc_sticky: sticky=%b%b acc=%h required 11 8", sticky_c, sticky_v, acc);
        end
        @(negedge clk);
        n_checks++;
        if ({alu_a, alu_b, alu_s} !== {4'd8, 4'd8, 3'd2}) begin
            n_fail++;
            $display("FAIL acc_idle_hold: a=%h b=%h s=%h required 8 8 2", alu_a, alu_b, alu_s);
        end
        rsp_ready = 1'b1;
        @(negedge clk);
        rsp_ready = 1'b0;
        void'(exp_q.pop_front());
    endtask

    task automatic test_backpressure;
        int accepted;
        int drained;
        logic was;
        accepted = 0;
        rsp_ready = 1'b0;
        cmd_acc = 1'b0; cmd_wb = 1'b0; cmd_s = 3'd0; cmd_b = 4'd1;
        for (int cyc = 0; cyc < 10; cyc++) begin
            cmd_valid = (accepted < 3);
            cmd_a = 4'(accepted + 1);
            was = cmd_valid && cmd_ready;
            if (was) exp_q.push_back({4'(accepted + 2), 3'b000});
            @(negedge clk);
            if (was) accepted++;
        end
        cmd_valid = 1'b0;
        n_checks++;
        if (accepted != 2) begin
            n_fail++;
            $display("FAIL bp_accept_count: accepted=%0d required 2", accepted);
        end
        n_checks++;
        if ({cmd_ready, rsp_valid} !== 2'b01) begin
            n_fail++;
            $display("FAIL bp_full: ready/rsp_valid=%b required 01", {cmd_ready, rsp_valid});
        end
        drained = 0;
        for (int g = 0; g < 10 && exp_q.size() > 0; g++) begin
            rsp_ready = 1'b1;
            if (rsp_valid) begin
                n_checks++;
                if ({rsp_r, rsp_c, rsp_v, rsp_z} !== exp_q[0]) begin
                    n_fail++;
                    $display("FAIL bp_order: rsp=%h required %h",
                             {rsp_r, rsp_c, rsp_v, rsp_z}, exp_q[0]);
                end
                void'(exp_q.pop_front());
                drained++;
            end
            @(negedge clk);
        end
        rsp_ready = 1'b0;
        n_checks++;
        if (drained != 2 || rsp_valid !== 1'b0 || cmd_ready !== 1'b1) begin
            n_fail++;
            $display("FAIL bp_drain: drained=%0d rsp_valid=%b ready=%b required 2 0 1",
                     drained, rsp_valid, cmd_ready);
        end
    endtask

    task automatic test_back_to_back;
        rsp_ready = 1'b0;
        send_cmd(4'd4, 4'd4, 3'd0, 1'b0, 1'b0);
        @(negedge clk);
        send_cmd(4'd1, 4'd2, 3'd0, 1'b0, 1'b0);
        // Pop the first response on the same edge the second is captured.
        rsp_ready = 1'b1;
        @(negedge clk);
        rsp_ready = 1'b0;
        void'(exp_q.pop_front());
        n_checks++;
        if ({rsp_valid, rsp_r, rsp_c, rsp_v, rsp_z, cmd_ready} !== {1'b1, 4'd3, 3'b000, 1'b1}) begin
            n_fail++;
            $display("FAIL b2b_push_pop: v=%b r=%h cvz=%b%b%b ready=%b required 1 3 000 1",
                     rsp_valid, rsp_r, rsp_c, rsp_v, rsp_z, cmd_ready);
        end
        rsp_ready = 1'b1;
        @(negedge clk);
        rsp_ready = 1'b0;
        void'(exp_q.pop_front());
        n_checks++;
        if (rsp_valid !== 1'b0) begin
            n_fail++;
            $display("FAIL b2b_empty: rsp_valid=%b required 0", rsp_valid);
        end
    endtask

    task automatic test_reset_mid;
        rsp_ready = 1'b0;
        send_cmd(4'd2, 4'd2, 3'd0, 1'b0, 1'b0);
        @(negedge clk);
        send_cmd(4'd5, 4'd2, 3'd0, 1'b0, 1'b1);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        exp_q.delete();
        acc_m = 4'h0;
        n_checks++;
        if ({rsp_valid, acc, cmd_ready, dbg_state} !== {1'b0, 4'd0, 1'b1, 1'b0}) begin
            n_fail++;
            $display("FAIL mid_reset: rsp_valid=%b acc=%h ready=%b state=%b required 0 0 1 0",
                     rsp_valid, acc, cmd_ready, dbg_state);
        end
        n_checks++;
        if ({alu_a, sticky_c, sticky_v} !== 6'h0) begin
            n_fail++;
            $display("FAIL mid_reset_regs: alu_a=%h sticky=%b%b required 0 00",
                     alu_a, sticky_c, sticky_v);
        end
    endtask

    task automatic test_sticky;
        send_cmd(4'd8, 4'd8, 3'd0, 1'b0, 1'b0);
        clr_sticky = 1'b1;
        @(negedge clk);
        n_checks++;
        if ({sticky_c, sticky_v} !== 2'b11) begin
            n_fail++;
            $display("FAIL sticky_set_wins: sticky=%b%b required 11", sticky_c, sticky_v);
        end
        @(negedge clk);
        clr_sticky = 1'b0;
        n_checks++;
        if ({sticky_c, sticky_v} !== 2'b00) begin
            n_fail++;
            $display("FAIL sticky_clear: sticky=%b%b required 00", sticky_c, sticky_v);
        end
        n_checks++;
        if ({rsp_valid, rsp_r, rsp_c, rsp_v, rsp_z} !== {1'b1, 4'd0, 3'b111}) begin
            n_fail++;
            $display("FAIL sticky_rsp: v=%b r=%h cvz=%b%b%b required 1 0 111",
                     rsp_valid, rsp_r, rsp_c, rsp_v, rsp_z);
        end
        rsp_ready = 1'b1;
        @(negedge clk);
        rsp_ready = 1'b0;
        void'(exp_q.pop_front());
    endtask

    initial begin
        n_checks = 0; n_fail = 0; acc_m = 4'h0;
        rst = 1'b1; cmd_valid = 1'b0; cmd_a = '0; cmd_b = '0; cmd_s = '0;
        cmd_acc = 1'b0; cmd_wb = 1'b0; rsp_ready = 1'b0; clr_sticky = 1'b0;
        @(negedge clk);
        test_reset;
        test_basic;
        test_acc_source;
        test_backpressure;
        test_back_to_back;
        test_reset_mid;
        test_sticky;
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
